// File: rtl/gcd_avalon_host_if.sv
// Operand stream, result stream and Avalon-MM host bus between gcd_avalon_host and its neighbours.
// The host side uses the master modport; the environment (source, sink, slave) uses slave.
interface gcd_avalon_host_if;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;

    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_timeout;

    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;

    modport master (
        input  op_valid, op_a, op_b, res_ready, avm_readdata,
        output op_ready, res_valid, res_data, res_timeout,
        output avm_address, avm_chipselect, avm_read, avm_write, avm_byteenable, avm_writedata
    );

    modport slave (
        output op_valid, op_a, op_b, res_ready, avm_readdata,
        input  op_ready, res_valid, res_data, res_timeout,
        input  avm_address, avm_chipselect, avm_read, avm_write, avm_byteenable, avm_writedata
    );
endinterface

// File: rtl/gcd_avalon_host.sv
// Avalon-MM host that feeds operand pairs to the GCD slave, polls it for completion and
// streams the result out; a==0 is answered locally and every bus operation is time-bounded.
module gcd_avalon_host #(
    parameter int unsigned HOLDOFF  = 3,
    parameter int unsigned POLL_GAP = 2,
    parameter int unsigned TIMEOUT  = 65535
) (
    input  logic               clock,
    input  logic               resetn,
    gcd_avalon_host_if.master  bus,
    output logic               busy,
    output logic [15:0]        done_count
);

    localparam int unsigned TmoW   = $clog2(TIMEOUT + 1);
    localparam int unsigned CntMax = (HOLDOFF > POLL_GAP) ? HOLDOFF : POLL_GAP;
    localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);

    localparam logic [TmoW-1:0] TmoMax   = TmoW'(TIMEOUT);
    localparam logic [CntW-1:0] HoldInit = CntW'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);
    localparam logic [CntW-1:0] GapInit  = CntW'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);

    localparam logic [1:0] AddrOpA    = 2'd0;
    localparam logic [1:0] AddrOpB    = 2'd1;
    localparam logic [1:0] AddrResult = 2'd2;
    localparam logic [1:0] AddrStatus = 2'd3;

    typedef enum logic [2:0] {
        StIdle, StWrA, StWrB, StHold, StPoll, StGap, StRdRes, StOut
    } state_e;

    state_e          state_q, state_d;
    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [TmoW-1:0] tmo_inc;

    logic            op_ready_q, op_ready_d;
    logic            res_valid_q, res_valid_d;
    logic [31:0]     res_data_q, res_data_d;
    logic            res_timeout_q, res_timeout_d;
    logic            busy_q, busy_d;
    logic [15:0]     done_count_q, done_count_d;

    logic [1:0]      avm_address_q, avm_address_d;
    logic            avm_chipselect_q, avm_chipselect_d;
    logic            avm_read_q, avm_read_d;
    logic            avm_write_q, avm_write_d;
    logic [3:0]      avm_byteenable_q, avm_byteenable_d;
    logic [31:0]     avm_writedata_q, avm_writedata_d;

    assign tmo_inc = (tmo_q >= TmoMax) ? TmoMax : tmo_q + TmoW'(1);

    // Next-state and datapath updates
    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        cnt_d         = cnt_q;
        tmo_d         = tmo_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        done_count_d  = done_count_q;

        unique case (state_q)
            StIdle: begin
                if (op_ready_q && bus.op_valid) begin
                    a_d = bus.op_a;
                    b_d = bus.op_b;
                    if (bus.op_a == 32'd0) begin
                        // The slave never terminates for a==0, so answer it here.
                        res_data_d    = bus.op_b;
                        res_timeout_d = 1'b0;
                        state_d       = StOut;
                    end else begin
                        state_d = StWrA;
                    end
                end
            end
            StWrA: state_d = StWrB;
            StWrB: begin
                tmo_d   = '0;
                cnt_d   = HoldInit;
                state_d = StHold;
            end
            StHold: begin
                tmo_d = tmo_inc;
                if (cnt_q == '0) state_d = StPoll;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StPoll: begin
                tmo_d = tmo_inc;
                if (bus.avm_readdata[0]) begin
                    state_d = StRdRes;
                end else if (tmo_q >= TmoMax) begin
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                    state_d       = StOut;
                end else if (POLL_GAP == 0) begin
                    state_d = StPoll;
                end else begin
                    cnt_d   = GapInit;
                    state_d = StGap;
                end
            end
            StGap: begin
                tmo_d = tmo_inc;
                if (cnt_q == '0) state_d = StPoll;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StRdRes: begin
                res_data_d    = bus.avm_readdata;
                res_timeout_d = 1'b0;
                state_d       = StOut;
            end
            StOut: begin
                if (bus.res_ready) begin
                    done_count_d = done_count_q + 16'd1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it
    always_comb begin
        op_ready_d       = (state_d == StIdle);
        busy_d           = (state_d != StIdle);
        res_valid_d      = (state_d == StOut);
        avm_address_d    = 2'd0;
        avm_chipselect_d = 1'b0;
        avm_read_d       = 1'b0;
        avm_write_d      = 1'b0;
        avm_writedata_d  = '0;

        unique case (state_d)
            StWrA: begin
                avm_chipselect_d = 1'b1;
                avm_write_d      = 1'b1;
                avm_address_d    = AddrOpA;
                avm_writedata_d  = a_d;
            end
            StWrB: begin
                avm_chipselect_d = 1'b1;
                avm_write_d      = 1'b1;
                avm_address_d    = AddrOpB;
                avm_writedata_d  = b_d;
            end
            StPoll: begin
                avm_chipselect_d = 1'b1;
                avm_read_d       = 1'b1;
                avm_address_d    = AddrStatus;
            end
            StRdRes: begin
                avm_chipselect_d = 1'b1;
                avm_read_d       = 1'b1;
                avm_address_d    = AddrResult;
            end
            default: ;
        endcase

        avm_byteenable_d = avm_chipselect_d ? 4'hF : 4'h0;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q          <= StIdle;
            a_q              <= '0;
            b_q              <= '0;
            cnt_q            <= '0;
            tmo_q            <= '0;
            op_ready_q       <= 1'b0;
            res_valid_q      <= 1'b0;
            res_data_q       <= '0;
            res_timeout_q    <= 1'b0;
            busy_q           <= 1'b0;
            done_count_q     <= '0;
            avm_address_q    <= '0;
            avm_chipselect_q <= 1'b0;
            avm_read_q       <= 1'b0;
            avm_write_q      <= 1'b0;
            avm_byteenable_q <= '0;
            avm_writedata_q  <= '0;
        end else begin
            state_q          <= state_d;
            a_q              <= a_d;
            b_q              <= b_d;
            cnt_q            <= cnt_d;
            tmo_q            <= tmo_d;
            op_ready_q       <= op_ready_d;
            res_valid_q      <= res_valid_d;
            res_data_q       <= res_data_d;
            res_timeout_q    <= res_timeout_d;
            busy_q           <= busy_d;
            done_count_q     <= done_count_d;
            avm_address_q    <= avm_address_d;
            avm_chipselect_q <= avm_chipselect_d;
            avm_read_q       <= avm_read_d;
            avm_write_q      <= avm_write_d;
            avm_byteenable_q <= avm_byteenable_d;
            avm_writedata_q  <= avm_writedata_d;
        end
    end

    assign bus.op_ready       = op_ready_q;
    assign bus.res_valid      = res_valid_q;
    assign bus.res_data       = res_data_q;
    assign bus.res_timeout    = res_timeout_q;
    assign bus.avm_address    = avm_address_q;
    assign bus.avm_chipselect = avm_chipselect_q;
    assign bus.avm_read       = avm_read_q;
    assign bus.avm_write      = avm_write_q;
    assign bus.avm_byteenable = avm_byteenable_q;
    assign bus.avm_writedata  = avm_writedata_q;
    assign busy               = busy_q;
    assign done_count         = done_count_q;

endmodule

// File: tb/tb_gcd_avalon_host.sv
// Directed bench for gcd_avalon_host with a behavioural subtractive-GCD slave on the bus.
// Slave: STATUS clears two edges after the OP_B write, then one subtraction step per cycle.
module tb_gcd_avalon_host;

    logic        clock;
    logic        resetn;
    logic        busy;
    logic [15:0] done_count;

    int n_checks = 0;
    int n_fail   = 0;

    gcd_avalon_host_if bus_if ();

    gcd_avalon_host #(
        .HOLDOFF  (3),
        .POLL_GAP (2),
        .TIMEOUT  (64)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .bus        (bus_if),
        .busy       (busy),
        .done_count (done_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural GCD slave
    logic [31:0] sl_ra, sl_rb, sl_wa, sl_wb, sl_res;
    logic        sl_status, sl_run;
    logic [1:0]  sl_pend;

    always @(posedge clock) begin
        if (!resetn) begin
            sl_ra <= '0; sl_rb <= '0; sl_wa <= '0; sl_wb <= '0; sl_res <= '0;
            sl_status <= 1'b0; sl_run <= 1'b0; sl_pend <= '0;
        end else if (bus_if.avm_chipselect && bus_if.avm_write) begin
            if (bus_if.avm_address == 2'd0) sl_ra <= bus_if.avm_writedata;
            if (bus_if.avm_address == 2'd1) begin
                sl_rb   <= bus_if.avm_writedata;
                sl_wa   <= sl_ra;
                sl_wb   <= bus_if.avm_writedata;
                sl_pend <= 2'd2;
                sl_run  <= 1'b0;
            end
        end else if (sl_pend != 2'd0) begin
            sl_pend <= sl_pend - 2'd1;
            if (sl_pend == 2'd1) begin
                sl_status <= 1'b0;
                sl_run    <= 1'b1;
            end
        end else if (sl_run) begin
            if (sl_wb == 32'd0 || sl_wa == sl_wb) begin
                sl_res    <= sl_wa;
                sl_status <= 1'b1;
                sl_run    <= 1'b0;
            end else if (sl_wa > sl_wb) begin
                sl_wa <= sl_wa - sl_wb;
            end else begin
                sl_wb <= sl_wb - sl_wa;
            end
        end
    end

    always_comb begin
        case (bus_if.avm_address)
            2'd0:    bus_if.avm_readdata = sl_ra;
            2'd1:    bus_if.avm_readdata = sl_rb;
            2'd2:    bus_if.avm_readdata = sl_res;
            default: bus_if.avm_readdata = {31'd0, sl_status};
        endcase
    end

    // Bus protocol monitor
    int          n_cs = 0;
    int          n_bus_err = 0;
    int          n_b2b_b = 0;
    logic        prev_b = 1'b0;
    logic [31:0] last_wd_a = '0;
    logic [31:0] last_wd_b = '0;

    always @(negedge clock) begin
        if (bus_if.avm_chipselect) begin
            n_cs <= n_cs + 1;
            if (bus_if.avm_byteenable != 4'hF || (bus_if.avm_read == bus_if.avm_write))
                n_bus_err <= n_bus_err + 1;
            if (bus_if.avm_write && bus_if.avm_address == 2'd0) last_wd_a <= bus_if.avm_writedata;
            if (bus_if.avm_write && bus_if.avm_address == 2'd1) last_wd_b <= bus_if.avm_writedata;
            if (bus_if.avm_address == 2'd1 && prev_b) n_b2b_b <= n_b2b_b + 1;
        end else if (bus_if.avm_byteenable != 4'h0 || bus_if.avm_writedata != 32'd0 ||
                     bus_if.avm_read || bus_if.avm_write) begin
            n_bus_err <= n_bus_err + 1;
        end
        prev_b <= bus_if.avm_chipselect && bus_if.avm_address == 2'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where res_valid is first seen.
    // lat counts cycles from the handshake cycle (0) to the first res_valid cycle.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] data, output logic tmo, output int lat);
        int n;
        bus_if.op_a     = a;
        bus_if.op_b     = b;
        bus_if.op_valid = 1'b1;
        n = 0;
        while (!bus_if.op_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        bus_if.op_valid = 1'b0;
        lat = 1;
        while (!bus_if.res_valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check_eq({tag, "_res_valid"}, 32'(bus_if.res_valid), 32'd1);
        data = bus_if.res_data;
        tmo  = bus_if.res_timeout;
    endtask

    task automatic ack();
        bus_if.res_ready = 1'b1;
        @(negedge clock);
        bus_if.res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic        t;
        int          lat;
        int          cs0;
        int          n_bad;
        int          n;

        resetn           = 1'b0;
        bus_if.op_valid  = 1'b0;
        bus_if.op_a      = '0;
        bus_if.op_b      = '0;
        bus_if.res_ready = 1'b0;

        repeat (3) @(negedge clock);
        check_eq("rst_op_ready",   32'(bus_if.op_ready),       32'd0);
        check_eq("rst_res_valid",  32'(bus_if.res_valid),      32'd0);
        check_eq("rst_res_data",   bus_if.res_data,            32'd0);
        check_eq("rst_busy",       32'(busy),                  32'd0);
        check_eq("rst_done_count", 32'(done_count),            32'd0);
        check_eq("rst_chipselect", 32'(bus_if.avm_chipselect), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        check_eq("post_rst_op_ready", 32'(bus_if.op_ready), 32'd1);

        // (12,8) over the bus: polls at 6 and 9, RD_RES at 10
        bus_if.res_ready = 1'b1;
        do_op("gcd_12_8", 32'd12, 32'd8, d, t, lat);
        check_eq("gcd_12_8_data", d, 32'd4);
        check_eq("gcd_12_8_tmo",  32'(t), 32'd0);
        check_eq("gcd_12_8_lat",  32'(lat), 32'd11);
        @(negedge clock);
        bus_if.res_ready = 1'b0;
        check_eq("gcd_12_8_done_count", 32'(done_count), 32'd1);
        check_eq("gcd_12_8_valid_drop", 32'(bus_if.res_valid), 32'd0);
        check_eq("gcd_12_8_wr_a", last_wd_a, 32'd12);
        check_eq("gcd_12_8_wr_b", last_wd_b, 32'd8);

        // Local a==0 path: no bus traffic, result one cycle after handshake
        cs0 = n_cs;
        do_op("gcd_0_7", 32'd0, 32'd7, d, t, lat);
        check_eq("gcd_0_7_data", d, 32'd7);
        check_eq("gcd_0_7_lat",  32'(lat), 32'd1);
        ack();
        do_op("gcd_0_0", 32'd0, 32'd0, d, t, lat);
        check_eq("gcd_0_0_data", d, 32'd0);
        check_eq("gcd_0_0_tmo",  32'(t), 32'd0);
        ack();
        @(negedge clock);
        check_eq("local_no_bus", 32'(n_cs - cs0), 32'd0);

        // b==0 handled by the slave, then back-to-back op must not see stale 9
        do_op("gcd_9_0", 32'd9, 32'd0, d, t, lat);
        check_eq("gcd_9_0_data", d, 32'd9);
        check_eq("gcd_9_0_lat",  32'(lat), 32'd8);
        ack();
        do_op("gcd_48_36", 32'd48, 32'd36, d, t, lat);
        check_eq("gcd_48_36_data", d, 32'd12);
        check_eq("gcd_48_36_lat",  32'(lat), 32'd11);
        ack();

        // Timeout: first poll with counter >= 64 is at cycle 69
        do_op("tmo", 32'hFFFF_FFFF, 32'd1, d, t, lat);
        check_eq("tmo_flag", 32'(t), 32'd1);
        check_eq("tmo_data", d, 32'd0);
        check_eq("tmo_lat",  32'(lat), 32'd70);
        ack();
        do_op("gcd_21_14", 32'd21, 32'd14, d, t, lat);
        check_eq("gcd_21_14_data", d, 32'd7);
        check_eq("gcd_21_14_tmo",  32'(t), 32'd0);
        ack();
        check_eq("done_count_7", 32'(done_count), 32'd7);

        // Backpressure for 20 cycles
        do_op("bp", 32'd12, 32'd8, d, t, lat);
        cs0   = n_cs;
        n_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!bus_if.res_valid || bus_if.res_data != 32'd4 || bus_if.res_timeout ||
                bus_if.op_ready || bus_if.avm_chipselect || done_count != 16'd7)
                n_bad++;
        end
        check_eq("bp_unstable_cycles", 32'(n_bad), 32'd0);
        check_eq("bp_no_bus", 32'(n_cs - cs0), 32'd0);
        ack();
        check_eq("bp_done_count", 32'(done_count), 32'd8);
        check_eq("bp_op_ready",   32'(bus_if.op_ready), 32'd1);

        // Reset during POLL
        bus_if.op_a     = 32'd48;
        bus_if.op_b     = 32'd36;
        bus_if.op_valid = 1'b1;
        @(negedge clock);
        bus_if.op_valid = 1'b0;
        n = 0;
        while (!(bus_if.avm_read && bus_if.avm_address == 2'd3) && n < 50) begin
            @(negedge clock);
            n++;
        end
        check_eq("mid_rst_reached_poll", 32'(bus_if.avm_read), 32'd1);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check_eq("mid_rst_op_ready",    32'(bus_if.op_ready),       32'd0);
        check_eq("mid_rst_res_valid",   32'(bus_if.res_valid),      32'd0);
        check_eq("mid_rst_res_data",    bus_if.res_data,            32'd0);
        check_eq("mid_rst_res_timeout", 32'(bus_if.res_timeout),    32'd0);
        check_eq("mid_rst_busy",        32'(busy),                  32'd0);
        check_eq("mid_rst_done_count",  32'(done_count),            32'd0);
        check_eq("mid_rst_cs",          32'(bus_if.avm_chipselect), 32'd0);
        check_eq("mid_rst_read",        32'(bus_if.avm_read),       32'd0);
        check_eq("mid_rst_address",     32'(bus_if.avm_address),    32'd0);
        check_eq("mid_rst_byteenable",  32'(bus_if.avm_byteenable), 32'd0);
        @(negedge clock);
        check_eq("mid_rst_op_ready_after", 32'(bus_if.op_ready),  32'd1);
        check_eq("mid_rst_no_result",      32'(bus_if.res_valid), 32'd0);
        do_op("gcd_35_15", 32'd35, 32'd15, d, t, lat);
        check_eq("gcd_35_15_data", d, 32'd5);
        check_eq("gcd_35_15_lat",  32'(lat), 32'd14);
        ack();
        check_eq("gcd_35_15_done_count", 32'(done_count), 32'd1);

        @(negedge clock);
        check_eq("bus_protocol_errors", 32'(n_bus_err), 32'd0);
        check_eq("back_to_back_addr1",  32'(n_b2b_b),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
